mult: RTL and testbench
=======================

// Module: mult
// PURPOSE
//  Matrix-multiply engine for the MatMem accelerator: C = A x B, IEEE-754 fp32.
//  - Started by the top FSM when op_code == MAT_MUL.
//  - Reads A and B through two memory-request ports and writes C through a third.
//  - Computes one 8-element row segment of C at a time, then signals finish.
// PARAMETERS
//  A_BASE     0   word address of A[0][0] in memory A
//  B_BASE     0   word address of B[0][0] in memory B
//  RES_BASE   0   word address of C[0][0] in result memory
//  MUL_LAT    5   latency of mult_cycle_5 IP (cycles)
//  ADD_LAT    7   latency of add_cycle_7_area IP (cycles)
// PORTS
//  clock      in   1             single clock, rising edge
//  reset      in   1             asynchronous, active-high
//  MatMul_en  in   1             start/hold request; must stay high for whole op
//  op         in   meta_data_t   op_code, dimA1 (M), dimA2 (K), dimB1 (K), dimB2 (N)
//  finish     out  1             op complete (level)
//  memA       out  mem_t         read request to A memory (read, address)
//  memB       out  mem_t         read request to B memory
//  memRes     out  mem_t         write request to C memory (write, address, writedata)
//  readdataA  in   BANDWIDTH x DATA_WIDTH   A word, valid 1 cycle after memA.read
//  readdataB  in   BANDWIDTH x DATA_WIDTH   B word, valid 1 cycle after memB.read
// BEHAVIOUR
//  Layout
//   - Row-major; one word = BANDWIDTH (8) fp32 elements, element e in slice [e].
//   - KW = K/8, NW = N/8.
//   - Word addresses: A[i][w] = A_BASE + i*KW + w; B[k][w] = B_BASE + k*NW + w;
//     C[i][w] = RES_BASE + i*NW + w.
//  Reset
//   - State IDLE; finish = 0; all mem_t fields = 0; accumulators = 0.
//   - memA/memB never write; memRes never reads.
//  States
//   - IDLE: when MatMul_en = 1, latch op dims into registers and go to CHECK.
//   - CHECK: if any dim is 0, dimA2 != dimB1, or any dim % 8 != 0, go to DONE
//     (no memory traffic). Otherwise i = 0, j = 0, k = 0, acc[0..7] = +0.0,
//     go to FETCH.
//   - FETCH (1 cycle): memA.read = 1 at A[i][k/8]; memB.read = 1 at B[k][j].
//   - LATCH (1 cycle): a = readdataA[k%8]; b[0..7] = readdataB.
//   - MUL (MUL_LAT cycles): 8 parallel multipliers compute p[e] = a * b[e].
//   - ADD (ADD_LAT cycles): 8 parallel adders compute acc[e] = acc[e] + p[e].
//     - If k < K-1: k++ and go to FETCH.
//     - Else go to WRITE.
//   - WRITE (1 cycle): memRes.write = 1 at C[i][j], writedata = acc.
//     Then k = 0, acc = 0, and advance j (0..NW-1, innermost) and i (0..M-1).
//     Go to FETCH, or to DONE after the last (i, j).
//   - DONE: finish = 1. Hold until MatMul_en = 0, then IDLE (finish = 0 next cycle).
//  Timing
//   - Per k step: 2 + MUL_LAT + ADD_LAT = 14 cycles.
//   - Per C word: 14*K + 1 cycles.
//   - Total from IDLE exit to DONE entry: 1 + M*NW*(14*K + 1) cycles.
//  Request strobes
//   - mem_t strobes are combinational from state and asserted for exactly one cycle.
//   - All other fields are 0 when not active.
//  Abort and reset
//   - MatMul_en = 0 in any non-IDLE state: return to IDLE next cycle, discard
//     partial results, write nothing further.
//   - reset mid-op: immediate return to reset state.
//  Arithmetic
//   - fp32 via the existing IP; round/flag outputs are ignored.
//   - Accumulation order is k ascending.
//   - Counters are wide enough for DIM_WIDTH dims; no wrap within a legal op.
// STRUCTURE
//  Shared package (Macro.svh)
//   - DATA_WIDTH = 32, BANDWIDTH = 8, ADDR_WIDTH = 11, DIM_WIDTH.
//   - mem_t, meta_data_t, op_code_t (MAT_MUL).
//  Reuse
//   - Counter(WIDTH, INCR) for i/j/k and latency counters.
//   - Register(WIDTH) for dims, a, b, acc.
//  Natural sub-module: mult_lane (one multiplier + one adder + acc register),
//  instantiated x8.
// TESTING
//  1. M=K=N=8, A = identity (1.0 = 0x3F800000), B = integers 0..63
//     -> C == B; finish after 1 + 8*(113) = 905 cycles.
//  2. 8x8x8, A all 2.0, B all 3.0 -> every C element 48.0 (0x42400000);
//     exactly 8 memRes writes at RES_BASE + 0..7.
//  3. M=16, K=8, N=16, integer data
//     -> 32 writes in order i-major/j-minor, addresses RES_BASE + i*2 + j,
//        values match golden model.
//  4. dimA2 = 8, dimB1 = 16 (mismatch) -> finish = 1 two cycles after start;
//     no memA/memB/memRes strobes.
//  5. reset asserted mid-MUL -> outputs 0 immediately.
//     Restart with test 2 -> correct results.
//  6. MatMul_en dropped during ADD -> IDLE next cycle, no further writes,
//     finish stays 0.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, types and fp32 arithmetic helpers for the mult engine
package mult_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int BANDWIDTH  = 8;
  localparam int ADDR_WIDTH = 11;
  localparam int DIM_WIDTH  = 8;

  typedef enum logic [1:0] {OP_NOP = 2'd0, MAT_MUL = 2'd1} op_code_t;

  typedef enum logic [2:0] {
    IDLE, CHECK, FETCH, LATCH, MUL, ADD, WRITE, DONE
  } mult_state_t;

  typedef struct packed {
    op_code_t             op_code;
    logic [DIM_WIDTH-1:0] dimA1;
    logic [DIM_WIDTH-1:0] dimA2;
    logic [DIM_WIDTH-1:0] dimB1;
    logic [DIM_WIDTH-1:0] dimB2;
  } meta_data_t;

  typedef struct packed {
    logic                                 read;
    logic                                 write;
    logic [ADDR_WIDTH-1:0]                address;
    logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] writedata;
  } mem_t;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input int base,
      input logic [DIM_WIDTH-1:0] row, input logic [DIM_WIDTH-1:0] stride,
      input logic [DIM_WIDTH-1:0] col);
    return ADDR_WIDTH'(base + int'(row) * int'(stride) + int'(col));
  endfunction

  // Denormals flush to zero; round to nearest even.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sign;
    logic [47:0]       prod;
    logic [23:0]       mant;
    logic              g;
    logic              s;
    logic signed [9:0] e;
    logic [24:0]       rnd;
    sign = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sign, 31'd0};
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = signed'({2'b00, a[30:23]}) + signed'({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      mant = prod[47:24]; g = prod[23]; s = |prod[22:0]; e = e + 10'sd1;
    end else begin
      mant = prod[46:23]; g = prod[22]; s = |prod[21:0];
    end
    rnd = {1'b0, mant} + {24'd0, g & (s | mant[0])};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e = e + 10'sd1;
    end
    if (e <= 10'sd0) return {sign, 31'd0};
    if (e >= 10'sd255) return {sign, 8'hFF, 23'd0};
    return {sign, e[7:0], rnd[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x;
    logic [31:0]       y;
    logic [7:0]        d;
    logic [26:0]       mx;
    logic [26:0]       my;
    logic [27:0]       sum;
    logic              sticky;
    logic signed [9:0] e;
    logic [24:0]       rnd;
    sticky = 1'b0;
    if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // Three guard bits; everything shifted past them folds into bit 0.
    if (d >= 8'd27) begin
      my = 27'd1;
    end else begin
      sticky = |(my & ((27'd1 << d) - 27'd1));
      my = (my >> d) | {26'd0, sticky};
    end
    sum = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
    if (sum == 28'd0) return 32'd0;
    e = signed'({2'b00, x[30:23]});
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e = e + 10'sd1;
    end
    for (int s = 0; s < 26; s++) begin
      if (!sum[26]) begin
        sum = sum << 1;
        e = e - 10'sd1;
      end
    end
    rnd = {1'b0, sum[26:3]} + {24'd0, sum[2] & ((|sum[1:0]) | sum[3])};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e = e + 10'sd1;
    end
    if (e <= 10'sd0) return {x[31], 31'd0};
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], rnd[22:0]};
  endfunction
endpackage

// File: rtl/mult_lane.sv
// rtl/mult_lane.sv - one output column: pipelined fp32 multiplier, adder and accumulator
module mult_lane
  import mult_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int ADD_LAT = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  acc_en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] acc
);
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] mul_pipe [MUL_LAT];
  // The accumulator register is the last adder stage.
  logic [DATA_WIDTH-1:0] add_pipe [ADD_LAT-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      acc  <= '0;
      for (int s = 0; s < MUL_LAT; s++) mul_pipe[s] <= '0;
      for (int s = 0; s < ADD_LAT - 1; s++) add_pipe[s] <= '0;
    end else begin
      if (load) begin
        op_a <= a;
        op_b <= b;
      end
      mul_pipe[0] <= fp_mul(op_a, op_b);
      for (int s = 1; s < MUL_LAT; s++) mul_pipe[s] <= mul_pipe[s-1];
      add_pipe[0] <= fp_add(acc, mul_pipe[MUL_LAT-1]);
      for (int s = 1; s < ADD_LAT - 1; s++) add_pipe[s] <= add_pipe[s-1];
      if (clear) acc <= '0;
      else if (acc_en) acc <= add_pipe[ADD_LAT-2];
    end
  end
endmodule

// File: rtl/mult.sv
// rtl/mult.sv - fp32 matrix multiply engine: C = A x B, one 8-element row segment at a time
module mult
  import mult_pkg::*;
#(
  parameter int A_BASE   = 0,
  parameter int B_BASE   = 0,
  parameter int RES_BASE = 0,
  parameter int MUL_LAT  = 5,
  parameter int ADD_LAT  = 7
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 MatMul_en,
  input  meta_data_t                           op,
  output logic                                 finish,
  output mem_t                                 memA,
  output mem_t                                 memB,
  output mem_t                                 memRes,
  input  logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] readdataA,
  input  logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] readdataB
);
  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

  mult_state_t          state;
  op_code_t             code;
  logic [DIM_WIDTH-1:0] m, ka, kb, n;
  logic [DIM_WIDTH-1:0] i, j, k;
  logic [3:0]           cnt;
  logic [DIM_WIDTH-1:0] kw, nw;
  logic                 bad;
  logic                 load, clear, acc_en;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] acc_word;

  assign kw  = ka >> 3;
  assign nw  = n >> 3;
  assign bad = (code != MAT_MUL) || (m == '0) || (ka == '0) || (kb == '0) || (n == '0)
             || (ka != kb) || (|m[2:0]) || (|ka[2:0]) || (|kb[2:0]) || (|n[2:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      finish <= 1'b0;
      code   <= OP_NOP;
      m      <= '0;
      ka     <= '0;
      kb     <= '0;
      n      <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      cnt    <= '0;
    end else if (state != IDLE && !MatMul_en) begin
      // Abort: partial accumulators are dropped by the lane clear.
      state  <= IDLE;
      finish <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (MatMul_en) begin
          code  <= op.op_code;
          m     <= op.dimA1;
          ka    <= op.dimA2;
          kb    <= op.dimB1;
          n     <= op.dimB2;
          state <= CHECK;
        end
        CHECK: if (bad) begin
          state  <= DONE;
          finish <= 1'b1;
        end else begin
          i     <= '0;
          j     <= '0;
          k     <= '0;
          state <= FETCH;
        end
        FETCH: state <= LATCH;
        LATCH: begin
          cnt   <= '0;
          state <= MUL;
        end
        MUL: if (cnt == 4'(MUL_LAT - 1)) begin
          cnt   <= '0;
          state <= ADD;
        end else begin
          cnt <= cnt + 4'd1;
        end
        ADD: if (cnt == 4'(ADD_LAT - 1)) begin
          cnt <= '0;
          if (k == ka - ONE) begin
            state <= WRITE;
          end else begin
            k     <= k + ONE;
            state <= FETCH;
          end
        end else begin
          cnt <= cnt + 4'd1;
        end
        WRITE: begin
          k <= '0;
          if (j == nw - ONE) begin
            j <= '0;
            if (i == m - ONE) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              i     <= i + ONE;
              state <= FETCH;
            end
          end else begin
            j     <= j + ONE;
            state <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign load   = (state == LATCH);
  assign acc_en = (state == ADD) && (cnt == 4'(ADD_LAT - 1));
  assign clear  = (state == IDLE) || (state == CHECK) || (state == WRITE) || !MatMul_en;
  assign a_sel  = readdataA[k[2:0]];

  for (genvar e = 0; e < BANDWIDTH; e++) begin : g_lane
    mult_lane #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) u_lane (
      .clock  (clock),
      .reset  (reset),
      .load   (load),
      .clear  (clear),
      .acc_en (acc_en),
      .a      (a_sel),
      .b      (readdataB[e]),
      .acc    (acc_word[e])
    );
  end

  always_comb begin
    memA   = '0;
    memB   = '0;
    memRes = '0;
    if (state == FETCH) begin
      memA.read    = 1'b1;
      memA.address = word_addr(A_BASE, i, kw, k >> 3);
      memB.read    = 1'b1;
      memB.address = word_addr(B_BASE, k, nw, j);
    end
    if (state == WRITE) begin
      memRes.write     = 1'b1;
      memRes.address   = word_addr(RES_BASE, i, nw, j);
      memRes.writedata = acc_word;
    end
  end
endmodule

// File: tb/tb_mult.sv
// tb/tb_mult.sv - scoreboard bench for the mult matrix-multiply engine
module tb_mult;
  import mult_pkg::*;

  localparam int A_BASE   = 4;
  localparam int B_BASE   = 8;
  localparam int RES_BASE = 16;

  typedef logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] word_t;
  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    word_t                 data;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       MatMul_en;
  meta_data_t op;
  logic       finish;
  mem_t       memA, memB, memRes;
  word_t      readdataA, readdataB;

  word_t a_mem [64];
  word_t b_mem [64];
  int    av [16][16];
  int    bv [16][16];
  exp_t  sb [$];

  int compared = 0;
  int mismatched = 0;
  int writes = 0;
  int reads = 0;
  int illegal = 0;

  mult #(.A_BASE(A_BASE), .B_BASE(B_BASE), .RES_BASE(RES_BASE), .MUL_LAT(5), .ADD_LAT(7)) dut (
    .clock     (clock),
    .reset     (reset),
    .MatMul_en (MatMul_en),
    .op        (op),
    .finish    (finish),
    .memA      (memA),
    .memB      (memB),
    .memRes    (memRes),
    .readdataA (readdataA),
    .readdataB (readdataB)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] want);
    compared++;
    if (obs !== want) begin
      mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] int_to_fp(input int v);
    int          p;
    logic [31:0] u;
    if (v == 0) return 32'd0;
    u = 32'(v);
    p = 0;
    for (int b = 0; b < 31; b++) if (u[b]) p = b;
    return {1'b0, 8'(127 + p), 23'(u << (23 - p))};
  endfunction

  // Memory model and output monitor, sampled away from the active edge.
  always @(negedge clock) begin
    if (memA.read) begin
      readdataA = a_mem[memA.address[5:0]];
      reads++;
    end
    if (memB.read) begin
      readdataB = b_mem[memB.address[5:0]];
      reads++;
    end
    if (memA.write || memB.write || memRes.read
        || (!memA.read && memA.address != '0) || (!memB.read && memB.address != '0)
        || (!memRes.write && (memRes.address != '0 || memRes.writedata != '0)))
      illegal++;
    if (memRes.write) begin
      writes++;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 256'(memRes.address), 256'(e.addr));
        check("wr_data", memRes.writedata, e.data);
      end
    end
  end

  task automatic load_mats(input int m, input int k, input int n, input int kind, input bit push);
    exp_t e;
    int   s;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        case (kind)
          0:       begin av[r][c] = (r == c) ? 1 : 0; bv[r][c] = r * 8 + c; end
          1:       begin av[r][c] = 2;                bv[r][c] = 3; end
          default: begin av[r][c] = (r + 2 * c) % 7;  bv[r][c] = (3 * r + c) % 5 + 1; end
        endcase
      end
    end
    for (int w = 0; w < 64; w++) begin
      a_mem[w] = '0;
      b_mem[w] = '0;
    end
    for (int i = 0; i < m; i++)
      for (int w = 0; w < k / 8; w++)
        for (int x = 0; x < 8; x++)
          a_mem[A_BASE + i * (k / 8) + w][x] = int_to_fp(av[i][w * 8 + x]);
    for (int kk = 0; kk < k; kk++)
      for (int w = 0; w < n / 8; w++)
        for (int x = 0; x < 8; x++)
          b_mem[B_BASE + kk * (n / 8) + w][x] = int_to_fp(bv[kk][w * 8 + x]);
    if (push) begin
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < n / 8; j++) begin
          e.addr = ADDR_WIDTH'(RES_BASE + i * (n / 8) + j);
          for (int x = 0; x < 8; x++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) s += av[i][kk] * bv[kk][j * 8 + x];
            e.data[x] = int_to_fp(s);
          end
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic set_op(input int m, input int ka, input int kb, input int n);
    op.op_code = MAT_MUL;
    op.dimA1   = DIM_WIDTH'(m);
    op.dimA2   = DIM_WIDTH'(ka);
    op.dimB1   = DIM_WIDTH'(kb);
    op.dimB2   = DIM_WIDTH'(n);
  endtask

  task automatic run_op(input string tag, input int m, input int ka, input int kb,
                        input int n, input int kind);
    bit valid;
    int cycles;
    int want_cycles;
    valid = m > 0 && ka > 0 && n > 0 && ka == kb && m % 8 == 0 && ka % 8 == 0 && n % 8 == 0;
    sb.delete();
    if (valid) load_mats(m, ka, n, kind, 1'b1);
    want_cycles = valid ? 2 + m * (n / 8) * (14 * ka + 1) : 2;
    writes  = 0;
    reads   = 0;
    illegal = 0;
    set_op(m, ka, kb, n);
    MatMul_en = 1'b1;
    cycles = 0;
    while (!finish && cycles < 20000) begin
      @(negedge clock);
      cycles++;
    end
    check({tag, "_cycles"}, 256'(cycles), 256'(want_cycles));
    check({tag, "_writes"}, 256'(writes), 256'(valid ? m * (n / 8) : 0));
    check({tag, "_reads"}, 256'(reads), 256'(valid ? 2 * m * (n / 8) * ka : 0));
    check({tag, "_pending"}, 256'(sb.size()), 256'(0));
    check({tag, "_illegal"}, 256'(illegal), 256'(0));
    MatMul_en = 1'b0;
    @(negedge clock);
    check({tag, "_finish_clr"}, 256'(finish), 256'(0));
    sb.delete();
  endtask

  initial begin
    int fin_seen;
    reset     = 1'b1;
    MatMul_en = 1'b0;
    op        = '0;
    readdataA = '0;
    readdataB = '0;
    repeat (2) @(negedge clock);
    check("rst_finish", 256'(finish), 256'(0));
    check("rst_memA", 256'({memA.read, memA.write, memA.address}), 256'(0));
    check("rst_memB", 256'({memB.read, memB.write, memB.address}), 256'(0));
    check("rst_memRes", 256'({memRes.read, memRes.write, memRes.address}), 256'(0));
    check("rst_wdata", memRes.writedata, 256'(0));
    reset = 1'b0;
    @(negedge clock);

    run_op("identity", 8, 8, 8, 8, 0);
    run_op("const", 8, 8, 8, 8, 1);
    run_op("rect", 16, 8, 8, 16, 2);
    run_op("k_mismatch", 8, 8, 16, 8, 0);
    run_op("zero_m", 0, 8, 8, 8, 0);
    run_op("k_not8", 8, 12, 12, 8, 0);
    run_op("zero_n", 8, 8, 8, 0, 0);

    // Asynchronous reset mid-op: first while fetching, then mid-multiply.
    for (int t = 0; t < 2; t++) begin
      load_mats(8, 8, 8, 1, 1'b0);
      set_op(8, 8, 8, 8);
      MatMul_en = 1'b1;
      repeat (t == 0 ? 2 : 4) @(negedge clock);
      check($sformatf("pre_rst_fetch_%0d", t), 256'(memA.read), 256'(t == 0 ? 1 : 0));
      reset = 1'b1;
      #1;
      check($sformatf("mid_rst_finish_%0d", t), 256'(finish), 256'(0));
      check($sformatf("mid_rst_strobes_%0d", t),
            256'({memA.read, memA.address, memB.read, memB.address, memRes.write, memRes.address}),
            256'(0));
      check($sformatf("mid_rst_wdata_%0d", t), memRes.writedata, 256'(0));
      MatMul_en = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
    end
    run_op("after_reset", 8, 8, 8, 8, 1);

    // Drop the enable during the first ADD phase; nothing more may happen.
    load_mats(8, 8, 8, 2, 1'b0);
    set_op(8, 8, 8, 8);
    writes   = 0;
    reads    = 0;
    fin_seen = 0;
    MatMul_en = 1'b1;
    repeat (10) @(negedge clock);
    MatMul_en = 1'b0;
    repeat (1200) begin
      @(negedge clock);
      if (finish) fin_seen++;
    end
    check("abort_writes", 256'(writes), 256'(0));
    check("abort_finish", 256'(fin_seen), 256'(0));
    check("abort_reads", 256'(reads), 256'(2));
    run_op("after_abort", 16, 8, 8, 16, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
